// File: rtl/jpeg_fifo_pkg.sv
// Shared constants and types for the padded FIFO.
//   DEF_DATA_W / DEF_DEPTH / DEF_PAD_W : default payload width, entry count, pad width
//   ptr_w()                            : pointer width (address bits plus a wrap bit)
//   err_flags_t                        : sticky overflow / underflow flags
package jpeg_fifo_pkg;

    localparam int DEF_DATA_W = 91;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_PAD_W  = 2;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic ovf;
        logic udf;
    } err_flags_t;

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage for ff_pad_fifo: one write port, one registered read port.
//   clk, rst       : clock; rst clears only the read register (the array is never cleared)
//   we/waddr/wdata : write port
//   re/raddr       : read request; rdata loads on the next rising edge and holds otherwise
//   rdata          : registered read data
module fifo_ram_2p #(
    parameter int DATA_W = 91,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata <= '0;
        else if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/ff_pad_fifo.sv
// Synchronous FIFO where each write may reserve extra dummy slots after its
// payload. Dummy slots keep stale memory contents and read back like real data.
//   clk, rst                 : clock, asynchronous active-high reset
//   wr_en, wr_data, wr_pad   : write request, payload, number of trailing dummy slots
//   rd_req                   : read request
//   rd_data, rd_valid        : registered read data, pulsed the cycle after an accepted read
//   empty, full, almost_full : occupancy decodes from the registered pointers
//   count                    : slots in use, dummy slots included
//   err_ovf, err_udf         : sticky error flags
// Optional feature macro: FF_PAD_FIFO_ERR_CHK_EN enables the sticky error flags;
// without it both flags are constant 0.
module ff_pad_fifo
    import jpeg_fifo_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int PAD_W    = DEF_PAD_W,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic [PAD_W-1:0]       wr_pad,
    input  logic                   rd_req,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   err_ovf,
    output logic                   err_udf
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);
    localparam logic [31:0] AF_U = AF_LEVEL;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW-1:0] wr_step;
    logic [31:0]   space, need;
    logic          wr_ok, rd_ok;

    // Pointer difference wraps modulo 2*DEPTH, so the wrap bit keeps full vs empty distinct.
    assign count       = wr_ptr - rd_ptr;
    assign empty       = (count == '0);
    assign full        = (count == PW'(DEPTH));
    assign almost_full = (32'(count) >= AF_U);

    // A write needs room for its payload plus every pad slot, or it is dropped whole.
    // Space is judged on the pre-edge count: a same-cycle read frees nothing.
    assign space   = 32'(DEPTH) - 32'(count);
    assign need    = 32'(wr_pad) + 32'd1;
    assign wr_ok   = wr_en && (space >= need);
    assign rd_ok   = rd_req && !empty;
    assign wr_step = PW'(wr_pad) + PW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + wr_step;
            if (rd_ok)
                rd_ptr <= rd_ptr + PW'(1);
            rd_valid <= rd_ok;
        end
    end

    fifo_ram_2p #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .re    (rd_ok),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

`ifdef FF_PAD_FIFO_ERR_CHK_EN
    err_flags_t err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else begin
            if (wr_en && !wr_ok)
                err_q.ovf <= 1'b1;
            if (rd_req && empty)
                err_q.udf <= 1'b1;
        end
    end

    assign err_ovf = err_q.ovf;
    assign err_udf = err_q.udf;
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule
